// File: rtl/data_memory_block.sv
// Block-organised data memory serving 128-bit cache refills and write-backs with fixed latency.
// Optional build macro: DMEM_RESET_CLEAR_EN (RESET also zeroes every array block).
module data_memory_block #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned LATENCY    = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         MEM_READ,
  input  logic         MEM_WRITE,
  input  logic [27:0]  MEM_ADDRESS,
  input  logic [127:0] MEM_WRITEDATA,
  output logic [127:0] MEM_READDATA,
  output logic         MEM_BUSYWAIT
);

  localparam int unsigned DEPTH   = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned BLOCK_W = 128;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]            state;
  logic [1:0]            next_state;
  logic [CNT_W-1:0]      cnt;
  logic                  op_write;
  logic [ADDR_WIDTH-1:0] idx;
  logic [BLOCK_W-1:0]    wdata;
  logic [BLOCK_W-1:0]    mem [DEPTH];

  logic req_c;
  logic fire_c;

  assign req_c  = MEM_READ | MEM_WRITE;
  assign fire_c = (state == ACCESS) && (cnt == '0);

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and stall; the stall tracks the request combinationally while idle
  always_comb begin
    next_state   = state;
    MEM_BUSYWAIT = 1'b0;
    case (state)
      IDLE: begin
        MEM_BUSYWAIT = req_c;
        if (req_c) next_state = ACCESS;
      end
      ACCESS: begin
        MEM_BUSYWAIT = 1'b1;
        if (cnt == '0) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request capture, latency counter and read data; a write wins over a simultaneous read
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt          <= '0;
      op_write     <= 1'b0;
      idx          <= '0;
      wdata        <= '0;
      MEM_READDATA <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_c) begin
            op_write <= MEM_WRITE;
            idx      <= MEM_ADDRESS[ADDR_WIDTH-1:0];
            wdata    <= MEM_WRITEDATA;
            cnt      <= CNT_W'(LATENCY - 1);
          end
        end
        ACCESS: begin
          if (cnt != '0)     cnt          <= cnt - CNT_W'(1);
          else if (!op_write) MEM_READDATA <= mem[idx];
        end
        default: ;
      endcase
    end
  end

`ifdef DMEM_RESET_CLEAR_EN
  // Storage array, cleared on reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (fire_c && op_write) begin
      mem[idx] <= wdata;
    end
  end
`else
  // Storage array, contents retained across reset
  always_ff @(posedge CLK) begin
    if (fire_c && op_write) mem[idx] <= wdata;
  end
`endif

endmodule

// File: tb/tb_data_memory_block.sv
// Directed self-checking bench for data_memory_block (LATENCY=4, ADDR_WIDTH=6).
module tb_data_memory_block;

  logic         CLK;
  logic         RESET;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] D_A5  = {16{8'hA5}};
  localparam logic [127:0] D_10  = 128'h1010_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] D_20  = 128'h2020_FFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999;
  localparam logic [127:0] D_41  = 128'h4141_0123_4567_89AB_CDEF_0F1E_2D3C_4B5A;
  localparam logic [127:0] D_9O  = 128'h9999_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] D_9N  = 128'h9999_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE;

  data_memory_block #(.ADDR_WIDTH(6), .LATENCY(4)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .MEM_READ     (MEM_READ),
    .MEM_WRITE    (MEM_WRITE),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Initiator: raise a request (called 1ns after a posedge), return in the DONE cycle
  task automatic run_op(input logic rd, input logic wr, input logic [27:0] a,
                        input logic [127:0] d, output int busy_cycles,
                        output logic busy_at_start);
    MEM_READ      = rd;
    MEM_WRITE     = wr;
    MEM_ADDRESS   = a;
    MEM_WRITEDATA = d;
    #1;
    busy_at_start = MEM_BUSYWAIT;
    busy_cycles   = busy_at_start ? 1 : 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge CLK); #1;
      if (!MEM_BUSYWAIT) return;
      busy_cycles++;
    end
    busy_cycles = -1;
  endtask

  task automatic release_req();
    @(posedge CLK); #1;
    MEM_READ  = 1'b0;
    MEM_WRITE = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; MEM_READ = 1'b0; MEM_WRITE = 1'b0;
    MEM_ADDRESS = '0; MEM_WRITEDATA = '0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (MEM_BUSYWAIT !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b exp=0", MEM_BUSYWAIT);
    end
    checks++;
    if (MEM_READDATA !== 128'd0) begin
      failures++; $display("FAIL reset_readdata got=%h exp=0", MEM_READDATA);
    end
    RESET = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_first_read();
    int n; logic b;
`ifndef DMEM_RESET_CLEAR_EN
    run_op(1'b0, 1'b1, 28'h5, 128'd0, n, b);
    release_req();
`endif
    run_op(1'b1, 1'b0, 28'h5, 128'd0, n, b);
    checks++;
    if (b !== 1'b1) begin
      failures++; $display("FAIL read5_busy_same_cycle got=%b exp=1", b);
    end
    checks++;
    if (n != 5) begin
      failures++; $display("FAIL read5_busy_cycles got=%0d exp=5", n);
    end
    checks++;
    if (MEM_READDATA !== 128'd0) begin
      failures++; $display("FAIL read5_data got=%h exp=0", MEM_READDATA);
    end
    release_req();
  endtask

  task automatic test_write_read();
    int n; logic b;
    run_op(1'b0, 1'b1, 28'h3, D_A5, n, b);
    checks++;
    if (n != 5) begin
      failures++; $display("FAIL write3_busy_cycles got=%0d exp=5", n);
    end
    release_req();
    run_op(1'b1, 1'b0, 28'h3, 128'd0, n, b);
    checks++;
    if (n != 5) begin
      failures++; $display("FAIL read3_busy_cycles got=%0d exp=5", n);
    end
    checks++;
    if (MEM_READDATA !== D_A5) begin
      failures++; $display("FAIL read3_data got=%h exp=%h", MEM_READDATA, D_A5);
    end
    release_req();
  endtask

  task automatic test_back_to_back();
    int n; logic b;
    run_op(1'b0, 1'b1, 28'h20, D_20, n, b);
    release_req();
    run_op(1'b0, 1'b1, 28'h10, D_10, n, b);
    // Write-back ack edge: swap straight to the refill read
    @(posedge CLK); #1;
    run_op(1'b1, 1'b0, 28'h20, 128'd0, n, b);
    checks++;
    if (b !== 1'b1) begin
      failures++; $display("FAIL b2b_busy_after_done got=%b exp=1", b);
    end
    checks++;
    if (MEM_READDATA !== D_20 || n != 5) begin
      failures++; $display("FAIL b2b_refill_data got=%h/%0d exp=%h/5", MEM_READDATA, n, D_20);
    end
    release_req();
    run_op(1'b1, 1'b0, 28'h10, 128'd0, n, b);
    checks++;
    if (MEM_READDATA !== D_10) begin
      failures++; $display("FAIL b2b_writeback_data got=%h exp=%h", MEM_READDATA, D_10);
    end
    release_req();
  endtask

  task automatic test_wrap();
    int n; logic b;
    run_op(1'b0, 1'b1, 28'h041, D_41, n, b);
    release_req();
    run_op(1'b1, 1'b0, 28'h001, 128'd0, n, b);
    checks++;
    if (MEM_READDATA !== D_41) begin
      failures++; $display("FAIL wrap_data got=%h exp=%h", MEM_READDATA, D_41);
    end
    release_req();
  endtask

  task automatic test_read_write_both();
    int n; logic b;
    run_op(1'b1, 1'b0, 28'h3, 128'd0, n, b);
    release_req();
    run_op(1'b1, 1'b1, 28'h7, 128'h1234, n, b);
    checks++;
    if (MEM_READDATA !== D_A5) begin
      failures++; $display("FAIL both_readdata_unchanged got=%h exp=%h", MEM_READDATA, D_A5);
    end
    release_req();
    run_op(1'b1, 1'b0, 28'h7, 128'd0, n, b);
    checks++;
    if (MEM_READDATA !== 128'h1234) begin
      failures++; $display("FAIL both_block7 got=%h exp=1234", MEM_READDATA);
    end
    release_req();
  endtask

  task automatic test_reset_mid_access();
    int n; logic b;
    logic [127:0] exp9;
    run_op(1'b0, 1'b1, 28'h9, D_9O, n, b);
    release_req();
    MEM_WRITE = 1'b1; MEM_ADDRESS = 28'h9; MEM_WRITEDATA = D_9N;
    @(posedge CLK); #2;
    RESET = 1'b1; MEM_WRITE = 1'b0;
    #1;
    checks++;
    if (MEM_BUSYWAIT !== 1'b0) begin
      failures++; $display("FAIL rst_mid_busy got=%b exp=0", MEM_BUSYWAIT);
    end
    checks++;
    if (MEM_READDATA !== 128'd0) begin
      failures++; $display("FAIL rst_mid_readdata got=%h exp=0", MEM_READDATA);
    end
    repeat (6) @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(posedge CLK); #1;
    run_op(1'b1, 1'b0, 28'h9, 128'd0, n, b);
`ifdef DMEM_RESET_CLEAR_EN
    exp9 = 128'd0;
`else
    exp9 = D_9O;
`endif
    checks++;
    if (MEM_READDATA !== exp9 || n != 5) begin
      failures++; $display("FAIL rst_mid_block9 got=%h/%0d exp=%h/5", MEM_READDATA, n, exp9);
    end
    release_req();
  endtask

  initial begin
    test_reset();
    test_first_read();
    test_write_read();
    test_back_to_back();
    test_wrap();
    test_read_write_both();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
